parity_frame_ctrl: RTL
======================

Name: parity_frame_ctrl

Overview:
- Sequences serial parity generation for parallel words.
- Accepts an N-bit word over a valid/ready handshake and shifts it out LSB-first on a serial valid/ready port, tracking running parity.
- Appends one even-parity bit as the final beat and reports the frame's parity flag.
- Sits between a parallel producer and a 1-bit serial link or parity tracker.

Parameters:
- N, 8, data word width in bits; legal range N >= 1.
- CW, $clog2(N) (minimum 1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N  parallel word
- in_valid  input  1  producer offers in_data
- in_ready  output  1  controller can accept a word
- ser_data  output  1  current serial bit
- ser_valid  output  1  ser_data is valid
- ser_ready  input  1  consumer accepts ser_data this cycle
- ser_last  output  1  current beat is the parity bit
- parity_flag  output  1  parity of the last completed frame: 1 = even count of ones, 0 = odd
- frame_done  output  1  one-cycle pulse after a frame's parity beat is accepted

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; ser_valid=0; ser_data=0; ser_last=0.
  - parity_flag=1 (zero ones counts as even); frame_done=0; shift register, counter and accumulator cleared.
  - Reset asserted mid-frame discards the frame; no frame_done.
- Running parity accumulator (acc) convention: acc=1 means even ones so far; acc starts at 1 and toggles on each accepted 1 bit.
- States: IDLE, SHIFT, PAR.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&&in_ready: latch in_data into shreg, cnt=0, acc=1, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1, ser_data=shreg[0], ser_last=0.
  - On ser_ready: acc <= acc ^ shreg[0], shreg shifts right, cnt++.
  - If cnt==N-1 on that handshake, go to PAR.
- PAR:
  - ser_valid=1, ser_data=~acc (even-parity bit: total ones including this bit is even), ser_last=1.
  - On ser_ready: parity_flag <= acc, frame_done <= 1 for one cycle, go to IDLE.
- Stall: with ser_ready low, all outputs and state hold indefinitely.
- Latency: a word accepted at edge k drives its first bit in cycle k+1. With ser_ready constantly high the frame occupies N+1 cycles. frame_done is high in the first IDLE cycle after the parity handshake, and in_ready is also high in that cycle, so back-to-back frames are allowed.
- N=1: SHIFT lasts one beat, then PAR.
- in_valid is ignored outside IDLE; the producer must hold the word until in_ready.
- parity_flag changes only on frame completion.

Optional Feature:
- Macro: PARITY_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in SHIFT or PAR returns to IDLE on the next edge with ser_valid=0, no frame_done, parity_flag unchanged. abort takes priority over a simultaneous ser_ready handshake.
  - abort in IDLE has no effect. A word offered with abort high in IDLE is accepted normally.
- Not defined: no abort port; a frame, once accepted, always completes unless reset.

Test Plan:
- Nominal: in_data=8'd101 (0b01100101), ser_ready=1 → ser_data 1,0,1,0,0,1,1,0 then parity beat 0 with ser_last=1; frame_done pulses; parity_flag=1.
- Odd word: in_data=8'h07 → parity beat 1, parity_flag=0. Then in_data=8'h00 → eight 0 bits, parity beat 0, parity_flag=1.
- Backpressure: in_data=8'hFF; ser_ready low 3 cycles at bit 2 and low 2 cycles on the parity beat → ser_data/ser_last held stable; total 9 accepted beats; parity beat 0; parity_flag=1.
- Back-to-back: in_valid held high with 8'h01 then 8'h03 → second word accepted in the frame_done cycle; parity beats 1 then 0; no idle beat between frames beyond the accept cycle.
- Reset mid-frame: rst_n low during bit 4 of 8'h0F → outputs go to reset values immediately, no frame_done, parity_flag=1; the next word 8'h01 completes normally with parity_flag=0.
- PARITY_ABORT_EN: abort pulsed with ser_ready=1 during bit 3 of 8'h07 → IDLE next cycle, no frame_done, parity_flag keeps its prior value; the next frame completes normally.

Source files
------------

// File: rtl/parity_frame_ctrl.sv
// rtl/parity_frame_ctrl.sv - parallel word to LSB-first serial frame with trailing even-parity beat
// Optional abort input when PARITY_ABORT_EN is defined.
module parity_frame_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         ser_data,
   output logic         ser_valid,
   input  logic         ser_ready,
`ifdef PARITY_ABORT_EN
   input  logic         abort,
`endif
   output logic         ser_last,
   output logic         parity_flag,
   output logic         frame_done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   shreg;
   logic [CW-1:0]  cnt;
   logic           acc;
   logic           load, shift, done;
   logic           abort_hit;

`ifdef PARITY_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      done      = 1'b0;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      ser_last  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            ser_data  = shreg[0];
            // abort wins over a handshake in the same cycle
            if (abort_hit) begin
               state_nxt = IDLE;
            end else if (ser_ready) begin
               shift = 1'b1;
               if (cnt == CW'(N - 1))
                  state_nxt = PAR;
            end
         end
         PAR: begin
            ser_valid = 1'b1;
            ser_data  = ~acc;
            ser_last  = 1'b1;
            if (abort_hit) begin
               state_nxt = IDLE;
            end else if (ser_ready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         cnt         <= '0;
         acc         <= 1'b1;
         parity_flag <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= done;
         if (load) begin
            shreg <= in_data;
            cnt   <= '0;
            acc   <= 1'b1;
         end else if (shift) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + CW'(1);
            acc   <= acc ^ shreg[0];
         end
         if (done)
            parity_flag <= acc;
      end
   end

endmodule
